// File: rtl/key_event_scheduler.sv
// Debounces N_KEYS raw buttons and serialises their press/release edges onto one
// valid/ready event channel, serving keys in round-robin order.
module key_event_scheduler #(
   parameter  int N_KEYS          = 8,
   parameter  int DEBOUNCE_CYCLES = 270000,
   localparam int ID_W            = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key,
   output logic [N_KEYS-1:0] key_clean,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [ID_W-1:0]   evt_id,
   output logic              evt_press,
   output logic              overflow
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_KEYS - 1);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_t;

   state_t state;
   state_t state_next;

   logic [N_KEYS-1:0] key_m;
   logic [N_KEYS-1:0] key_s;
   logic [CNT_W-1:0]  cnt [N_KEYS];
   logic [N_KEYS-1:0] deb_edge;
   logic [N_KEYS-1:0] pending;
   logic [N_KEYS-1:0] ptype;
   logic [N_KEYS-1:0] load_mask;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   sel_id;
   logic              sel_found;
   logic              load;
   logic              handshake;

   // Two-stage synchroniser for the asynchronous button levels.
   always_ff @(posedge clock) begin
      if (!reset) begin
         key_m <= '0;
         key_s <= '0;
      end else begin
         key_m <= key;
         key_s <= key_m;
      end
   end

   // A level change is accepted on its DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
   always_comb begin
      deb_edge = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         deb_edge[i] = (key_s[i] != key_clean[i]) && (cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         key_clean <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            if (key_s[i] == key_clean[i]) begin
               cnt[i] <= '0;
            end else if (deb_edge[i]) begin
               key_clean[i] <= key_s[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Round-robin pick: first pending key at or after ptr, wrapping past the top.
   always_comb begin
      int              idx;
      logic [ID_W-1:0] cand;
      idx       = 0;
      cand      = '0;
      sel_id    = '0;
      sel_found = 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_KEYS) begin
            idx = idx - N_KEYS;
         end
         cand = ID_W'(idx);
         if (!sel_found && pending[cand]) begin
            sel_found = 1'b1;
            sel_id    = cand;
         end
      end
   end

   assign load      = (state == IDLE) && sel_found;
   assign handshake = (state == PRESENT) && evt_ready;
   assign load_mask = load ? (N_KEYS'(1) << sel_id) : '0;

   // A fresh edge beats the clear of a key being loaded, so that edge is kept, not lost.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pending  <= '0;
         ptype    <= '0;
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            if (deb_edge[i]) begin
               pending[i] <= 1'b1;
               ptype[i]   <= key_s[i];
            end else if (load_mask[i]) begin
               pending[i] <= 1'b0;
            end
         end
         overflow <= |(deb_edge & pending & ~load_mask);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (sel_found) state_next = PRESENT;
         PRESENT: if (evt_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Event register holds id/type until the handshake; ptr moves past the served key.
   always_ff @(posedge clock) begin
      if (!reset) begin
         evt_id    <= '0;
         evt_press <= 1'b0;
         ptr       <= '0;
      end else begin
         if (load) begin
            evt_id    <= sel_id;
            evt_press <= ptype[sel_id];
         end
         if (handshake) begin
            ptr <= (evt_id == ID_LAST) ? '0 : evt_id + ID_W'(1);
         end
      end
   end

   always_comb begin
      evt_valid = (state == PRESENT);
   end

endmodule
